// File: rtl/relu_grad_pipe.sv
// Backward-pass ReLU gate: stores one derivative mask bit per forward sample in
// a FIFO and gates incoming gradients with those bits in order, one register deep.
module relu_grad_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          fwd_valid,
  input  logic signed [DATA_WIDTH-1:0]  fwd_in,
  output logic                          fwd_ready,
  input  logic                          grad_valid,
  input  logic signed [DATA_WIDTH-1:0]  grad_in,
  output logic                          grad_ready,
  output logic signed [DATA_WIDTH-1:0]  grad_out,
  output logic                          grad_out_valid,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow_err,
  output logic                          underflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DEPTH-1:0]             mask_r;
  logic [AW-1:0]                wr_ptr_r, wr_ptr_s;
  logic [AW-1:0]                rd_ptr_r, rd_ptr_s;
  logic [LW-1:0]                count_r, count_s;
  logic signed [DATA_WIDTH-1:0] grad_out_r, grad_out_s;
  logic                         grad_out_valid_r, grad_out_valid_s;
  logic                         overflow_r, overflow_s;
  logic                         underflow_r, underflow_s;
  logic                         fwd_ready_s, grad_ready_s;
  logic                         wr_en_s, rd_en_s;

  // Ready depends on registered occupancy only, so no valid-to-ready path exists.
  assign fwd_ready_s  = (count_r != LW'(DEPTH));
  assign grad_ready_s = (count_r != {LW{1'b0}});
  assign wr_en_s      = fwd_valid && fwd_ready_s;
  assign rd_en_s      = grad_valid && grad_ready_s;

  // Next-state for pointers, occupancy, output stage and sticky error flags.
  always_comb begin
    wr_ptr_s         = wr_ptr_r;
    rd_ptr_s         = rd_ptr_r;
    count_s          = count_r;
    grad_out_s       = grad_out_r;
    grad_out_valid_s = 1'b0;
    overflow_s       = overflow_r;
    underflow_s      = underflow_r;
    if (clear) begin
      wr_ptr_s    = {AW{1'b0}};
      rd_ptr_s    = {AW{1'b0}};
      count_s     = {LW{1'b0}};
      overflow_s  = 1'b0;
      underflow_s = 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_s = wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (rd_en_s) begin
        rd_ptr_s         = rd_ptr_r + AW'(1);
        grad_out_s       = mask_r[rd_ptr_r] ? grad_in : {DATA_WIDTH{1'b0}};
        grad_out_valid_s = 1'b1;
      end else begin
        rd_ptr_s         = rd_ptr_r;
        grad_out_valid_s = 1'b0;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_s = count_r + LW'(1);
        2'b01:   count_s = count_r - LW'(1);
        default: count_s = count_r;
      endcase
      if (fwd_valid && !fwd_ready_s) begin
        overflow_s = 1'b1;
      end else begin
        overflow_s = overflow_r;
      end
      if (grad_valid && !grad_ready_s) begin
        underflow_s = 1'b1;
      end else begin
        underflow_s = underflow_r;
      end
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r         <= {AW{1'b0}};
      rd_ptr_r         <= {AW{1'b0}};
      count_r          <= {LW{1'b0}};
      grad_out_r       <= {DATA_WIDTH{1'b0}};
      grad_out_valid_r <= 1'b0;
      overflow_r       <= 1'b0;
      underflow_r      <= 1'b0;
    end else begin
      wr_ptr_r         <= wr_ptr_s;
      rd_ptr_r         <= rd_ptr_s;
      count_r          <= count_s;
      grad_out_r       <= grad_out_s;
      grad_out_valid_r <= grad_out_valid_s;
      overflow_r       <= overflow_s;
      underflow_r      <= underflow_s;
    end
  end

  // Mask storage: zero and positive samples pass gradient, negative ones block it.
  always_ff @(posedge clk) begin
    if (rst_n && !clear && wr_en_s) begin
      mask_r[wr_ptr_r] <= ~fwd_in[DATA_WIDTH-1];
    end
  end

  assign fwd_ready      = fwd_ready_s;
  assign grad_ready     = grad_ready_s;
  assign grad_out       = grad_out_r;
  assign grad_out_valid = grad_out_valid_r;
  assign level          = count_r;
  assign overflow_err   = overflow_r;
  assign underflow_err  = underflow_r;

endmodule

// File: tb/tb_relu_grad_pipe.sv
// Self-checking bench for relu_grad_pipe against a queue-based reference model.
module tb_relu_grad_pipe;

  localparam int DW    = 16;
  localparam int DEPTH = 64;

  logic                 clk = 1'b0;
  logic                 rst_n, clear, fwd_valid, grad_valid;
  logic signed [DW-1:0] fwd_in, grad_in;
  logic                 fwd_ready, grad_ready, grad_out_valid;
  logic signed [DW-1:0] grad_out;
  logic [6:0]           level;
  logic                 overflow_err, underflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  bit                   q[$];
  logic signed [DW-1:0] exp_go;
  logic                 exp_gov, exp_of, exp_uf;

  always #5 clk = ~clk;

  relu_grad_pipe #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .fwd_valid(fwd_valid), .fwd_in(fwd_in), .fwd_ready(fwd_ready),
    .grad_valid(grad_valid), .grad_in(grad_in), .grad_ready(grad_ready),
    .grad_out(grad_out), .grad_out_valid(grad_out_valid), .level(level),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  // Reference model: a queue of mask bits, advanced from the spec's transfer rules.
  task automatic tick();
    bit w, r, m;
    if (!rst_n) begin
      q.delete(); exp_go = '0; exp_gov = 1'b0; exp_of = 1'b0; exp_uf = 1'b0;
    end else if (clear) begin
      q.delete(); exp_gov = 1'b0; exp_of = 1'b0; exp_uf = 1'b0;
    end else begin
      w = fwd_valid && (q.size() < DEPTH);
      r = grad_valid && (q.size() > 0);
      if (fwd_valid && !w) exp_of = 1'b1;
      if (grad_valid && !r) exp_uf = 1'b1;
      if (r) begin
        m = q.pop_front();
        exp_go  = m ? grad_in : 16'sd0;
        exp_gov = 1'b1;
      end else begin
        exp_gov = 1'b0;
      end
      if (w) q.push_back(fwd_in >= 16'sd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 1'b0; fwd_valid = 1'b0; grad_valid = 1'b0;
  endtask

  task automatic do_clear();
    idle(); clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic write_n(input int n);
    for (int i = 0; i < n; i++) begin
      fwd_valid = 1'b1; fwd_in = DW'($urandom); tick();
    end
    fwd_valid = 1'b0;
  endtask

  task automatic check_state(input string tag);
    n_tests++;
    if (grad_out_valid !== exp_gov || level !== 7'(q.size()) ||
        overflow_err !== exp_of || underflow_err !== exp_uf) begin
      n_fail++;
      $display("FAIL %s: gov=%b lvl=%0d of=%b uf=%b, required gov=%b lvl=%0d of=%b uf=%b",
               tag, grad_out_valid, level, overflow_err, underflow_err,
               exp_gov, q.size(), exp_of, exp_uf);
    end
    n_tests++;
    if (grad_out !== exp_go) begin
      n_fail++;
      $display("FAIL %s_data: grad_out=%0d required %0d", tag, grad_out, exp_go);
    end
  endtask

  task automatic test_reset();
    idle(); fwd_in = '0; grad_in = '0;
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    n_tests++;
    if (level !== 7'd0 || grad_out !== 16'sd0 || grad_out_valid !== 1'b0 ||
        overflow_err !== 1'b0 || underflow_err !== 1'b0 ||
        fwd_ready !== 1'b1 || grad_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: lvl=%0d go=%0d gov=%b of=%b uf=%b fr=%b gr=%b, required all 0 except fr=1",
               level, grad_out, grad_out_valid, overflow_err, underflow_err, fwd_ready, grad_ready);
    end
  endtask

  task automatic test_basic();
    logic signed [DW-1:0] f[4] = '{16'sd5, -16'sd3, 16'sd0, -16'sd32768};
    logic signed [DW-1:0] g[4] = '{16'sd100, 16'sd100, -16'sd7, 16'sd20};
    logic signed [DW-1:0] e[4] = '{16'sd100, 16'sd0, -16'sd7, 16'sd0};
    for (int i = 0; i < 4; i++) begin
      fwd_valid = 1'b1; fwd_in = f[i]; tick();
    end
    fwd_valid = 1'b0;
    n_tests++;
    if (level !== 7'd4) begin
      n_fail++; $display("FAIL basic_level: level=%0d required 4", level);
    end
    for (int i = 0; i < 4; i++) begin
      grad_valid = 1'b1; grad_in = g[i]; tick();
      n_tests++;
      if (grad_out_valid !== 1'b1 || grad_out !== e[i] || level !== 7'(3 - i)) begin
        n_fail++;
        $display("FAIL basic_grad%0d: gov=%b go=%0d lvl=%0d required 1 %0d %0d",
                 i, grad_out_valid, grad_out, level, e[i], 3 - i);
      end
    end
    idle(); tick();
    check_state("basic_idle");
  endtask

  task automatic test_overflow();
    do_clear();
    write_n(DEPTH);
    fwd_valid = 1'b1; fwd_in = 16'sd1;
    n_tests++;
    if (fwd_ready !== 1'b0) begin
      n_fail++; $display("FAIL ovf_ready: fwd_ready=%b required 0", fwd_ready);
    end
    tick();
    check_state("ovf_drop");
    fwd_valid = 1'b1; fwd_in = -16'sd9; grad_valid = 1'b1; grad_in = 16'sd77;
    n_tests++;
    if (fwd_ready !== 1'b0) begin
      n_fail++; $display("FAIL ovf_rw_ready: fwd_ready=%b required 0", fwd_ready);
    end
    tick(); idle();
    check_state("ovf_rw");
    n_tests++;
    if (level !== 7'd63) begin
      n_fail++; $display("FAIL ovf_rw_level: level=%0d required 63", level);
    end
  endtask

  task automatic test_underflow();
    do_clear();
    grad_valid = 1'b1; grad_in = 16'sd55; fwd_valid = 1'b1; fwd_in = 16'sd9;
    n_tests++;
    if (grad_ready !== 1'b0) begin
      n_fail++; $display("FAIL udf_ready: grad_ready=%b required 0", grad_ready);
    end
    tick();
    check_state("udf_drop");
    fwd_valid = 1'b0; grad_in = 16'sd55; tick(); idle();
    check_state("udf_read");
    n_tests++;
    if (grad_out !== 16'sd55 || underflow_err !== 1'b1) begin
      n_fail++; $display("FAIL udf_value: go=%0d uf=%b required 55 1", grad_out, underflow_err);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    write_n(3);
    for (int i = 0; i < 200; i++) begin
      fwd_valid  = 1'b1;
      fwd_in     = (i % 2 == 0) ? DW'($urandom_range(0, 32767))
                                : -DW'($urandom_range(1, 32768));
      grad_valid = 1'b1;
      grad_in    = DW'($urandom);
      tick();
      check_state("steady");
      n_tests++;
      if (level !== 7'd3) begin
        n_fail++; $display("FAIL steady_level: cycle %0d level=%0d required 3", i, level);
      end
    end
    idle();
  endtask

  task automatic test_clear();
    do_clear();
    write_n(10);
    fwd_valid = 1'b1; fwd_in = 16'sd4; grad_valid = 1'b1; grad_in = 16'sd3;
    clear = 1'b1; tick(); idle();
    check_state("clear");
    n_tests++;
    if (level !== 7'd0 || grad_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL clear_zero: lvl=%0d gov=%b required 0 0", level, grad_out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_clear();
    grad_valid = 1'b1; grad_in = 16'sd1; tick(); idle();
    write_n(6);
    grad_valid = 1'b1; grad_in = 16'sd30; tick(); idle();
    check_state("pre_rst");
    fwd_valid = 1'b1; grad_valid = 1'b1; rst_n = 1'b0; tick(); rst_n = 1'b1; idle();
    check_state("mid_rst");
    n_tests++;
    if (level !== 7'd0 || grad_out !== 16'sd0 || grad_out_valid !== 1'b0 ||
        underflow_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_zero: lvl=%0d go=%0d gov=%b uf=%b required 0",
                         level, grad_out, grad_out_valid, underflow_err);
    end
    fwd_valid = 1'b1; fwd_in = 16'sd7; tick(); idle();
    grad_valid = 1'b1; grad_in = 16'sd12; tick(); idle();
    n_tests++;
    if (grad_out !== 16'sd12 || grad_out_valid !== 1'b1) begin
      n_fail++; $display("FAIL post_rst: go=%0d gov=%b required 12 1", grad_out, grad_out_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
